// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the I/D memory port arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, SVC_I, SVC_D} state_t;
   localparam int LAT_MAX = 15;
   localparam int WIDX_HI = 14;
   localparam int WIDX_LO = 2;
   function automatic logic [WIDX_HI-WIDX_LO:0] word_idx(input logic [31:0] a);
      return a[WIDX_HI:WIDX_LO];
   endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker; a tie goes to the port not served last.
module rr_pick2 (
   input  logic req_i,
   input  logic req_d,
   input  logic last_d,
   output logic gnt_i,
   output logic gnt_d
);
   assign gnt_d = req_d && (!req_i || !last_d);
   assign gnt_i = req_i && (!req_d || last_d);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises I-fetch and data accesses onto one memory with a fixed service latency.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LAT = 7,
   parameter int AW  = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          I_REQ,
   input  logic [AW-1:0] I_ADDR,
   output logic [31:0]   I_RDATA,
   output logic          I_ACK,
   output logic          I_STALL,
   input  logic          D_REQ,
   input  logic          D_WE,
   input  logic [AW-1:0] D_ADDR,
   input  logic [31:0]   D_WDATA,
   output logic [31:0]   D_RDATA,
   output logic          D_ACK,
   output logic          D_STALL,
   output logic [AW-1:0] M_ADDR,
   output logic          M_WE,
   output logic [31:0]   M_WDATA,
   input  logic [31:0]   M_RDATA,
   output logic          BUSY
);
   state_t        r_state, w_next;
   logic [3:0]    r_cnt;
   logic          r_last_d, r_we, r_i_ack, r_d_ack;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_wdata, r_i_rdata, r_d_rdata;
   logic          w_el_i, w_el_d, w_gnt_i, w_gnt_d, w_idle, w_last, w_grant;
   // a port still holding REQ in its own ACK cycle is not eligible again yet
   assign w_el_i  = I_REQ && !r_i_ack;
   assign w_el_d  = D_REQ && !r_d_ack;
   assign w_idle  = r_state == IDLE;
   assign w_last  = !w_idle && r_cnt == 4'd0;
   assign w_grant = w_idle && (w_gnt_i || w_gnt_d);
   rr_pick2 u_pick (
      .req_i  (w_el_i),
      .req_d  (w_el_d),
      .last_d (r_last_d),
      .gnt_i  (w_gnt_i),
      .gnt_d  (w_gnt_d)
   );
   always_ff @(posedge CLK) r_state <= RST ? IDLE : w_next;
   always_comb w_next = w_idle ? (w_gnt_d ? SVC_D : w_gnt_i ? SVC_I : IDLE) : w_last ? IDLE : r_state;
   // RST gates the strobe so a reset landing in the final cycle never commits the write
   always_comb begin
      M_ADDR = w_idle ? '0 : r_addr;
      M_WE   = w_last && r_we && !RST;
   end
   assign M_WDATA = r_wdata;
   assign BUSY    = !w_idle;
   assign I_ACK   = r_i_ack;
   assign D_ACK   = r_d_ack;
   assign I_RDATA = r_i_rdata;
   assign D_RDATA = r_d_rdata;
   assign I_STALL = I_REQ && !r_i_ack;
   assign D_STALL = D_REQ && !r_d_ack;
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt     <= 4'd0;
         r_last_d  <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_i_ack   <= 1'b0;
         r_d_ack   <= 1'b0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         r_i_ack <= w_last && r_state == SVC_I;
         r_d_ack <= w_last && r_state == SVC_D;
         if (w_grant) begin
            r_addr   <= w_gnt_d ? D_ADDR : I_ADDR;
            r_we     <= w_gnt_d && D_WE;
            r_last_d <= w_gnt_d;
            r_cnt    <= 4'(LAT - 1);
         end else if (!w_idle && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_grant && w_gnt_d) r_wdata <= D_WDATA;
         if (w_last && r_state == SVC_I) r_i_rdata <= M_RDATA;
         if (w_last && r_state == SVC_D && !r_we) r_d_rdata <= M_RDATA;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomised checks of the arbiter against a transaction-level memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;
  localparam int LAT = 7;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic        i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        i_ack, i_stall, d_ack, d_stall, m_we, busy;
  logic        i1_req = 0, d1_req = 0, d1_we = 0;
  logic [31:0] i1_addr = 0, d1_addr = 0, d1_wdata = 0;
  logic [31:0] i1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;
  logic        i1_ack, i1_stall, d1_ack, d1_stall, m1_we, busy1;
  logic [31:0] mem7 [8192];
  logic [31:0] mem1 [8192];
  logic [31:0] refm [8192];
  int          n_chk = 0, n_fail = 0, we_pulses = 0;
  logic [31:0] we_addr = 0, e_i_rd = 0, e_d_rd = 0;
  mem_port_arbiter #(.LAT(LAT), .AW(32)) dut (
    .CLK(clk), .RST(rst), .I_REQ(i_req), .I_ADDR(i_addr), .I_RDATA(i_rdata), .I_ACK(i_ack),
    .I_STALL(i_stall), .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_RDATA(d_rdata), .D_ACK(d_ack), .D_STALL(d_stall), .M_ADDR(m_addr), .M_WE(m_we),
    .M_WDATA(m_wdata), .M_RDATA(m_rdata), .BUSY(busy));
  mem_port_arbiter #(.LAT(1), .AW(32)) dut1 (
    .CLK(clk), .RST(rst), .I_REQ(i1_req), .I_ADDR(i1_addr), .I_RDATA(i1_rdata), .I_ACK(i1_ack),
    .I_STALL(i1_stall), .D_REQ(d1_req), .D_WE(d1_we), .D_ADDR(d1_addr), .D_WDATA(d1_wdata),
    .D_RDATA(d1_rdata), .D_ACK(d1_ack), .D_STALL(d1_stall), .M_ADDR(m1_addr), .M_WE(m1_we),
    .M_WDATA(m1_wdata), .M_RDATA(m1_rdata), .BUSY(busy1));
  assign m_rdata  = mem7[m_addr[14:2]];
  assign m1_rdata = mem1[m1_addr[14:2]];
  always @(posedge clk) if (m_we) mem7[m_addr[14:2]] <= m_wdata;
  always @(posedge clk) if (m1_we) mem1[m1_addr[14:2]] <= m1_wdata;
  always @(negedge clk) if (m_we) begin
    we_pulses <= we_pulses + 1;
    we_addr   <= m_addr;
  end
  function automatic logic [31:0] init_val(input int w);
    return (w == 2) ? 32'd20 : 32'h1000_0000 + 32'(w) * 32'd7;
  endfunction
  task automatic access(input bit dp, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output int stalls, output bit to);
    int t0;
    @(negedge clk);
    if (dp) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
    else begin i_req = 1; i_addr = a; end
    t0 = cyc; lat = 0; stalls = 0; to = 1;
    #1 if (dp ? d_stall : i_stall) stalls++;
    for (int n = 0; n < 100 && to; n++) begin
      @(negedge clk);
      if (dp ? d_ack : i_ack) begin
        to = 0; lat = cyc - t0;
        if (dp && we) refm[word_idx(a)] = wd;
        else if (dp) e_d_rd = refm[word_idx(a)];
        else e_i_rd = refm[word_idx(a)];
      end else if (dp ? d_stall : i_stall) stalls++;
    end
    i_req = 0; d_req = 0; d_we = 0;
  endtask
  task automatic tie(input logic [31:0] ia, input logic [31:0] da, output int ti, output int td, output bit to);
    int t0;
    @(negedge clk);
    i_req = 1; d_req = 1; d_we = 0; i_addr = ia; d_addr = da; t0 = cyc; ti = -1; td = -1;
    for (int n = 0; n < 200 && (i_req || d_req); n++) begin
      @(negedge clk);
      if (i_ack && i_req) begin ti = cyc - t0; e_i_rd = refm[word_idx(ia)]; i_req = 0; end
      if (d_ack && d_req) begin td = cyc - t0; e_d_rd = refm[word_idx(da)]; d_req = 0; end
    end
    to = i_req || d_req; i_req = 0; d_req = 0;
  endtask
  task automatic do_reset();
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
    rst = 0; e_i_rd = 0; e_d_rd = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, m_we, i_ack, d_ack, i_stall, d_stall, m_addr, i_rdata, d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b we=%b iack=%b dack=%b maddr=%h ird=%h drd=%h, expected all 0",
               busy, m_we, i_ack, d_ack, m_addr, i_rdata, d_rdata);
    end
    n_chk++;
    if ({busy1, m1_we, i1_ack, d1_ack, m1_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_lat1: got busy=%b we=%b maddr=%h, expected 0", busy1, m1_we, m1_addr);
    end
    rst = 0;
  endtask
  task automatic test_uncontended_read();
    int lat, st; bit to;
    access(1, 0, 32'd8, 0, lat, st, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL d_read_timeout: no D_ACK within bound"); end
    n_chk++; if (lat != LAT + 1) begin n_fail++; $display("FAIL d_read_latency: got %0d expected %0d", lat, LAT + 1); end
    n_chk++; if (d_rdata !== 32'd20) begin n_fail++; $display("FAIL d_read_data: got %0d expected 20", d_rdata); end
    n_chk++; if (st != LAT + 1) begin n_fail++; $display("FAIL d_read_stall_cycles: got %0d expected %0d", st, LAT + 1); end
    n_chk++; if (d_stall !== 1'b0) begin n_fail++; $display("FAIL d_stall_in_ack: got %b expected 0", d_stall); end
    access(0, 0, 32'd12, 0, lat, st, to);
    n_chk++; if (to || lat != LAT + 1) begin n_fail++; $display("FAIL i_read_latency: got %0d (to=%b) expected %0d", lat, to, LAT + 1); end
    n_chk++; if (i_rdata !== e_i_rd) begin n_fail++; $display("FAIL i_read_data: got %h expected %h", i_rdata, e_i_rd); end
  endtask
  task automatic test_write_read();
    int lat, st, p; bit to; logic [31:0] ir, dr;
    p = we_pulses; ir = e_i_rd; dr = e_d_rd;
    access(1, 1, 32'd4, 32'h55, lat, st, to);
    n_chk++; if (to || lat != LAT + 1) begin n_fail++; $display("FAIL d_write_latency: got %0d (to=%b) expected %0d", lat, to, LAT + 1); end
    n_chk++; if (we_pulses - p != 1) begin n_fail++; $display("FAIL d_write_we_pulses: got %0d expected 1", we_pulses - p); end
    n_chk++; if (we_addr !== 32'd4) begin n_fail++; $display("FAIL d_write_maddr: got %h expected 4", we_addr); end
    n_chk++; if (d_rdata !== dr) begin n_fail++; $display("FAIL d_rdata_after_write: got %h expected %h", d_rdata, dr); end
    access(1, 0, 32'd4, 0, lat, st, to);
    n_chk++; if (to || d_rdata !== 32'h55) begin n_fail++; $display("FAIL d_read_back: got %h (to=%b) expected 55", d_rdata, to); end
    n_chk++; if (we_pulses - p != 1) begin n_fail++; $display("FAIL read_we_pulses: got %0d expected 1", we_pulses - p); end
    n_chk++; if (i_rdata !== ir) begin n_fail++; $display("FAIL i_rdata_held: got %h expected %h", i_rdata, ir); end
  endtask
  task automatic test_tie();
    int ti, td, lat, st; bit to;
    do_reset();
    tie(32'd16, 32'd20, ti, td, to);
    n_chk++; if (to || td != LAT + 1) begin n_fail++; $display("FAIL tie1_d_first: got %0d (to=%b) expected %0d", td, to, LAT + 1); end
    n_chk++; if (ti != 2 * (LAT + 1)) begin n_fail++; $display("FAIL tie1_i_second: got %0d expected %0d", ti, 2 * (LAT + 1)); end
    n_chk++;
    if (i_rdata !== e_i_rd || d_rdata !== e_d_rd) begin
      n_fail++;
      $display("FAIL tie1_data: got %h/%h expected %h/%h", i_rdata, d_rdata, e_i_rd, e_d_rd);
    end
    access(1, 0, 32'd24, 0, lat, st, to);
    tie(32'd28, 32'd32, ti, td, to);
    n_chk++; if (to || ti != LAT + 1) begin n_fail++; $display("FAIL tie2_i_first: got %0d (to=%b) expected %0d", ti, to, LAT + 1); end
    n_chk++; if (td != 2 * (LAT + 1)) begin n_fail++; $display("FAIL tie2_d_second: got %0d expected %0d", td, 2 * (LAT + 1)); end
  endtask
  task automatic test_reset_mid_write();
    int p, ti, td; bit to, seen;
    p = we_pulses; seen = 0;
    @(negedge clk); d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h77;
    repeat (3) @(negedge clk);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midwrite_busy: got %b expected 1", busy); end
    rst = 1; d_req = 0; d_we = 0;
    @(negedge clk);
    n_chk++;
    if ({busy, m_we, i_ack, d_ack, i_stall, d_stall, m_addr, i_rdata, d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL midwrite_reset_outputs: got busy=%b we=%b dack=%b maddr=%h ird=%h drd=%h, expected all 0",
               busy, m_we, d_ack, m_addr, i_rdata, d_rdata);
    end
    rst = 0; e_i_rd = 0; e_d_rd = 0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (d_ack) seen = 1;
    end
    n_chk++; if (seen) begin n_fail++; $display("FAIL midwrite_no_ack: got D_ACK expected none"); end
    n_chk++; if (we_pulses != p) begin n_fail++; $display("FAIL midwrite_no_we: got %0d pulses expected 0", we_pulses - p); end
    n_chk++; if (mem7[16] !== refm[16]) begin n_fail++; $display("FAIL midwrite_mem: got %h expected %h", mem7[16], refm[16]); end
    tie(32'd0, 32'd4, ti, td, to);
    n_chk++;
    if (to || td != LAT + 1 || ti != 2 * (LAT + 1)) begin
      n_fail++;
      $display("FAIL midwrite_tie_d_first: got d=%0d i=%0d expected d=%0d i=%0d", td, ti, LAT + 1, 2 * (LAT + 1));
    end
  endtask
  task automatic test_traffic(input bit dense, input int n_acc);
    int i_gap = 0, d_gap = 0, i_t0 = 0, d_t0 = 0, last = -1, ni = 0, nd = 0, lat;
    do_reset();
    for (int n = 0; n < 4000 && (ni < n_acc || nd < n_acc); n++) begin
      @(negedge clk);
      n_chk++;
      if (i_stall !== (i_req && !i_ack) || d_stall !== (d_req && !d_ack)) begin
        n_fail++;
        $display("FAIL traffic_stall: got i=%b d=%b expected i=%b d=%b", i_stall, d_stall, i_req && !i_ack, d_req && !d_ack);
      end
      n_chk++;
      if ((i_ack && !i_req) || (d_ack && !d_req) || (i_ack && d_ack)) begin
        n_fail++;
        $display("FAIL traffic_ack: got iack=%b dack=%b with ireq=%b dreq=%b", i_ack, d_ack, i_req, d_req);
      end
      if (i_ack && i_req) begin
        lat = cyc - i_t0;
        n_chk++;
        if (lat < LAT + 1 || lat > 2 * (LAT + 1)) begin
          n_fail++;
          $display("FAIL traffic_i_wait: got %0d expected %0d..%0d", lat, LAT + 1, 2 * (LAT + 1));
        end
        if (dense && nd < n_acc) begin
          n_chk++; if (last == 0) begin n_fail++; $display("FAIL traffic_alternation: got I twice expected D"); end
        end
        e_i_rd = refm[word_idx(i_addr)]; last = 0; ni++; i_req = 0;
        i_gap = dense ? 0 : int'($urandom_range(0, 4));
      end
      if (d_ack && d_req) begin
        lat = cyc - d_t0;
        n_chk++;
        if (lat < LAT + 1 || lat > 2 * (LAT + 1)) begin
          n_fail++;
          $display("FAIL traffic_d_wait: got %0d expected %0d..%0d", lat, LAT + 1, 2 * (LAT + 1));
        end
        if (dense && ni < n_acc) begin
          n_chk++; if (last == 1) begin n_fail++; $display("FAIL traffic_alternation: got D twice expected I"); end
        end
        if (d_we) refm[word_idx(d_addr)] = d_wdata;
        else e_d_rd = refm[word_idx(d_addr)];
        last = 1; nd++; d_req = 0; d_we = 0;
        d_gap = dense ? 0 : int'($urandom_range(0, 4));
      end
      n_chk++; if (i_rdata !== e_i_rd) begin n_fail++; $display("FAIL traffic_i_rdata: got %h expected %h", i_rdata, e_i_rd); end
      n_chk++; if (d_rdata !== e_d_rd) begin n_fail++; $display("FAIL traffic_d_rdata: got %h expected %h", d_rdata, e_d_rd); end
      if (!i_req && ni < n_acc) begin
        if (i_gap == 0) begin i_req = 1; i_addr = 32'($urandom_range(0, 15)) << 2; i_t0 = cyc; end
        else i_gap--;
      end
      if (!d_req && nd < n_acc) begin
        if (d_gap == 0) begin
          d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = 32'($urandom_range(0, 15)) << 2;
          d_wdata = $urandom; d_t0 = cyc;
        end else d_gap--;
      end
    end
    n_chk++;
    if (ni < n_acc || nd < n_acc) begin
      n_fail++;
      $display("FAIL traffic_timeout: got %0d/%0d expected %0d each", ni, nd, n_acc);
    end
    i_req = 0; d_req = 0; d_we = 0;
  endtask
  task automatic test_lat1();
    int ni = 0, nd = 0, prev;
    @(negedge clk);
    i1_req = 1; d1_req = 1; i1_addr = 0; d1_addr = 32'd12; prev = cyc;
    for (int n = 0; n < 60 && (ni < 3 || nd < 3); n++) begin
      @(negedge clk);
      if (i1_ack || d1_ack) begin
        n_chk++; if (cyc - prev != 2) begin n_fail++; $display("FAIL lat1_spacing: got %0d expected 2", cyc - prev); end
        prev = cyc;
      end
      if (i1_ack && i1_req) begin
        n_chk++;
        if (i1_rdata !== init_val(ni)) begin
          n_fail++;
          $display("FAIL lat1_i_data: got %h expected %h", i1_rdata, init_val(ni));
        end
        ni++;
        if (ni < 3) i1_addr = 32'(ni) * 32'd4; else i1_req = 0;
      end
      if (d1_ack && d1_req) begin
        n_chk++;
        if (d1_rdata !== init_val(3 + nd)) begin
          n_fail++;
          $display("FAIL lat1_d_data: got %h expected %h", d1_rdata, init_val(3 + nd));
        end
        nd++;
        if (nd < 3) d1_addr = 32'd12 + 32'(nd) * 32'd4; else d1_req = 0;
      end
    end
    n_chk++; if (ni != 3 || nd != 3) begin n_fail++; $display("FAIL lat1_count: got %0d/%0d expected 3/3", ni, nd); end
    i1_req = 0; d1_req = 0;
  endtask
  initial begin
    for (int w = 0; w < 8192; w++) begin
      mem7[w] = init_val(w); mem1[w] = init_val(w); refm[w] = init_val(w);
    end
    test_reset();
    test_uncontended_read();
    test_write_read();
    test_tie();
    test_reset_mid_write();
    test_traffic(1'b1, 10);
    test_traffic(1'b0, 40);
    test_lat1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
